// File: rtl/camera64x64_pkg.sv
// Shared types and constants for the 64x64 camera frame-capture sequencer.
package camera64x64_pkg;

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StTrig       = 3'd1,
        StWaitLookup = 3'd2,
        StWaitInt    = 3'd3,
        StRead       = 3'd4
    } cam_state_e;

    localparam int unsigned RowIdxW     = 6;
    localparam int unsigned DefClkDiv   = 4;
    localparam int unsigned DefTrigBits = 8;
    localparam logic [31:0] DefTimeout  = 32'h0000_0200;
    localparam int unsigned DefRows     = 64;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/camera64x64_ctrl_if.sv
// Host/camera/pixel-buffer signal bundle seen by the capture sequencer.
interface camera64x64_ctrl_if;

    logic                                start;
    logic                                abort;
    logic                                lookup;
    logic                                intr;
    logic                                row_ack;
    logic                                sclk;
    logic                                row_req;
    logic [camera64x64_pkg::RowIdxW-1:0] row_idx;
    logic                                busy;
    logic                                done;
    logic                                err;

    modport master (
        output start, abort, lookup, intr, row_ack,
        input  sclk, row_req, row_idx, busy, done, err
    );

    modport slave (
        input  start, abort, lookup, intr, row_ack,
        output sclk, row_req, row_idx, busy, done, err
    );

endinterface

// File: rtl/camera64x64_sclk_gen.sv
// SPI trigger burst generator: TrigBits SCLK pulses, each half-period ClkDiv cycles.
module camera64x64_sclk_gen
    import camera64x64_pkg::*;
#(
    parameter int unsigned ClkDiv   = DefClkDiv,
    parameter int unsigned TrigBits = DefTrigBits
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic sclk_o,
    output logic burst_done_o
);

    localparam int unsigned     DivW    = cnt_width(ClkDiv);
    localparam int unsigned     BitW    = cnt_width(TrigBits);
    localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(TrigBits - 1);

    logic [DivW-1:0] div_q, div_d;
    logic [BitW-1:0] bit_q, bit_d;
    logic            sclk_q, sclk_d;
    logic            toggle;

    always_comb begin
        toggle       = en_i && !clr_i && (div_q == DivLast);
        // Last falling edge of the burst ends TRIG on the same clock edge.
        burst_done_o = toggle && sclk_q && (bit_q == BitLast);
        div_d        = div_q;
        bit_d        = bit_q;
        sclk_d       = sclk_q;
        if (!en_i || clr_i || burst_done_o) begin
            div_d  = '0;
            bit_d  = '0;
            sclk_d = 1'b0;
        end else if (toggle) begin
            div_d  = '0;
            sclk_d = !sclk_q;
            if (sclk_q) begin
                bit_d = bit_q + BitW'(1);
            end
        end else begin
            div_d = div_q + DivW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= '0;
            bit_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bit_q  <= bit_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/camera64x64_ctrl.sv
// Frame-capture sequencer: trigger burst, LOOKUP/INT wait with timeout, row handshakes.
module camera64x64_ctrl
    import camera64x64_pkg::*;
#(
    parameter int unsigned ClkDiv   = DefClkDiv,
    parameter int unsigned TrigBits = DefTrigBits,
    parameter logic [31:0] Timeout  = DefTimeout,
    parameter int unsigned Rows     = DefRows
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    camera64x64_ctrl_if.slave        cam_io
);

    localparam logic [RowIdxW-1:0] RowLast = RowIdxW'(Rows - 1);
    localparam logic [31:0]        TmoLast = Timeout - 32'd1;

    cam_state_e         state_q;
    logic [31:0]        tmo_q;
    logic [RowIdxW-1:0] row_idx_q;
    logic               row_req_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               trig_en;
    logic               burst_done;

    assign trig_en = (state_q == StTrig);

    camera64x64_sclk_gen #(
        .ClkDiv   (ClkDiv),
        .TrigBits (TrigBits)
    ) u_sclk_gen (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (trig_en),
        .clr_i        (cam_io.abort),
        .sclk_o       (cam_io.sclk),
        .burst_done_o (burst_done)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            tmo_q     <= '0;
            row_idx_q <= '0;
            row_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cam_io.abort) begin
                state_q   <= StIdle;
                row_idx_q <= '0;
                row_req_q <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (cam_io.start) begin
                            state_q <= StTrig;
                            busy_q  <= 1'b1;
                            err_q   <= 1'b0;
                        end
                    end
                    StTrig: begin
                        if (burst_done) begin
                            state_q <= StWaitLookup;
                            tmo_q   <= '0;
                        end
                    end
                    StWaitLookup, StWaitInt: begin
                        tmo_q <= tmo_q + 32'd1;
                        // The awaited event beats a simultaneous timeout.
                        if (state_q == StWaitLookup && cam_io.lookup) begin
                            state_q <= StWaitInt;
                        end else if (state_q == StWaitInt && cam_io.intr) begin
                            state_q   <= StRead;
                            row_idx_q <= '0;
                            row_req_q <= 1'b1;
                        end else if (tmo_q == TmoLast) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end
                    StRead: begin
                        if (cam_io.row_ack) begin
                            if (row_idx_q == RowLast) begin
                                state_q   <= StIdle;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                                row_req_q <= 1'b0;
                                row_idx_q <= '0;
                            end else begin
                                row_idx_q <= row_idx_q + RowIdxW'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cam_io.row_req = row_req_q;
    assign cam_io.row_idx = row_idx_q;
    assign cam_io.busy    = busy_q;
    assign cam_io.done    = done_q;
    assign cam_io.err     = err_q;

endmodule

// File: tb/tb_camera64x64_ctrl.sv
// Bench for camera64x64_ctrl: two configurations, a phase/elapsed-time reference model,
// a vector table, directed corner sequences and random stimulus.
module tb_camera64x64_ctrl;

    typedef struct packed {
        int cd;
        int tb;
        int to;
        int rows;
    } cfg_t;

    localparam cfg_t CfgA = '{cd: 4, tb: 8, to: 512, rows: 64};
    localparam cfg_t CfgB = '{cd: 1, tb: 2, to: 16, rows: 4};

    localparam int PIdle = 0;
    localparam int PTrig = 1;
    localparam int PWl   = 2;
    localparam int PWi   = 3;
    localparam int PRead = 4;

    typedef struct {
        int ph;
        int t;
        int tw;
        int row;
        bit err;
        bit done;
    } mdl_t;

    typedef struct packed {
        logic [4:0]  in;
        logic [10:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, lookup = 1'b0, intr = 1'b0, row_ack = 1'b0;
    logic [4:0]  in_v;
    logic [10:0] out_a, out_b;
    int total = 0;
    int bad = 0;
    mdl_t ma, mb;
    vec_t vecs[17];

    always #5 clk = ~clk;

    camera64x64_ctrl_if if_a ();
    camera64x64_ctrl_if if_b ();

    assign if_a.start = start;   assign if_b.start = start;
    assign if_a.abort = abort;   assign if_b.abort = abort;
    assign if_a.lookup = lookup; assign if_b.lookup = lookup;
    assign if_a.intr = intr;     assign if_b.intr = intr;
    assign if_a.row_ack = row_ack; assign if_b.row_ack = row_ack;

    camera64x64_ctrl #(
        .ClkDiv(4), .TrigBits(8), .Timeout(32'd512), .Rows(64)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .cam_io(if_a)
    );

    camera64x64_ctrl #(
        .ClkDiv(1), .TrigBits(2), .Timeout(32'd16), .Rows(4)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .cam_io(if_b)
    );

    assign in_v  = {start, abort, lookup, intr, row_ack};
    assign out_a = {if_a.busy, if_a.sclk, if_a.row_req, if_a.row_idx, if_a.done, if_a.err};
    assign out_b = {if_b.busy, if_b.sclk, if_b.row_req, if_b.row_idx, if_b.done, if_b.err};

    function automatic mdl_t mdl_reset();
        mdl_t z;
        z.ph = PIdle; z.t = 0; z.tw = 0; z.row = 0; z.err = 1'b0; z.done = 1'b0;
        return z;
    endfunction

    // Phase plus elapsed-time bookkeeping; SCLK is derived from time spent in TRIG.
    function automatic mdl_t mdl_step(input mdl_t m, input cfg_t c, input logic [4:0] in);
        mdl_t n;
        logic st, ab, lk, it, ak;
        {st, ab, lk, it, ak} = in;
        n = m;
        n.done = 1'b0;
        n.t = m.t + 1;
        n.tw = m.tw + 1;
        if (ab) begin
            n.ph = PIdle;
            return n;
        end
        case (m.ph)
            PIdle: if (st) begin n.ph = PTrig; n.t = 0; n.err = 1'b0; end
            PTrig: if (m.t == 2 * c.cd * c.tb - 1) begin n.ph = PWl; n.tw = 0; end
            PWl: begin
                if (lk) n.ph = PWi;
                else if (m.tw == c.to - 1) begin n.ph = PIdle; n.err = 1'b1; end
            end
            PWi: begin
                if (it) begin n.ph = PRead; n.row = 0; end
                else if (m.tw == c.to - 1) begin n.ph = PIdle; n.err = 1'b1; end
            end
            PRead: begin
                if (ak) begin
                    if (m.row == c.rows - 1) begin n.ph = PIdle; n.done = 1'b1; end
                    else n.row = m.row + 1;
                end
            end
            default: n.ph = PIdle;
        endcase
        return n;
    endfunction

    function automatic logic [10:0] mdl_out(input mdl_t m, input cfg_t c);
        logic       s;
        logic [5:0] r;
        s = (m.ph == PTrig) && (((m.t / c.cd) % 2) == 1);
        r = (m.ph == PRead) ? 6'(m.row) : 6'd0;
        return {m.ph != PIdle, s, m.ph == PRead, r, m.done, m.err};
    endfunction

    function automatic logic [10:0] mkexp(input logic busy, input logic sclk, input logic req,
                                          input int idx, input logic done, input logic err);
        return {busy, sclk, req, 6'(idx), done, err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_abort();
        abort = 1'b1; tick(1); abort = 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= mdl_reset();
            mb <= mdl_reset();
        end else begin
            ma <= mdl_step(ma, CfgA, in_v);
            mb <= mdl_step(mb, CfgB, in_v);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_a", 32'(out_a), 32'(mdl_out(ma, CfgA)));
            check("model_b", 32'(out_b), 32'(mdl_out(mb, CfgB)));
        end
    end

    task automatic count_burst_a(input string tag);
        int   pulses;
        logic prev;
        pulses = 0;
        prev = 1'b0;
        start = 1'b1; tick(1); start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick(1);
            if (if_a.sclk && !prev) pulses++;
            prev = if_a.sclk;
        end
        check({tag, "_pulses"}, 32'(pulses), 32'd8);
        check({tag, "_wl"}, 32'({if_a.busy, if_a.sclk}), 32'b10);
    endtask

    task automatic run_frame_a(input string tag);
        count_burst_a(tag);
        tick(5);
        lookup = 1'b1; tick(1); lookup = 1'b0;
        tick(99);
        intr = 1'b1; row_ack = 1'b1; tick(1); intr = 1'b0;
        for (int r = 0; r < 64; r++) begin
            check({tag, "_row"}, 32'({if_a.row_req, if_a.row_idx}), 32'({1'b1, 6'(r)}));
            tick(1);
        end
        check({tag, "_done"}, 32'({if_a.busy, if_a.row_req, if_a.done, if_a.err}), 32'b0010);
        row_ack = 1'b0; tick(1);
        check({tag, "_done_low"}, 32'(if_a.done), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{in: 5'b11000, exp: mkexp(0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{in: 5'b10000, exp: mkexp(1, 0, 0, 0, 0, 0)};
        vecs[2]  = '{in: 5'b10000, exp: mkexp(1, 1, 0, 0, 0, 0)};
        vecs[3]  = '{in: 5'b00000, exp: mkexp(1, 0, 0, 0, 0, 0)};
        vecs[4]  = '{in: 5'b00000, exp: mkexp(1, 1, 0, 0, 0, 0)};
        vecs[5]  = '{in: 5'b00000, exp: mkexp(1, 0, 0, 0, 0, 0)};
        vecs[6]  = '{in: 5'b00010, exp: mkexp(1, 0, 0, 0, 0, 0)};
        vecs[7]  = '{in: 5'b00100, exp: mkexp(1, 0, 0, 0, 0, 0)};
        vecs[8]  = '{in: 5'b00010, exp: mkexp(1, 0, 1, 0, 0, 0)};
        vecs[9]  = '{in: 5'b00001, exp: mkexp(1, 0, 1, 1, 0, 0)};
        vecs[10] = '{in: 5'b00000, exp: mkexp(1, 0, 1, 1, 0, 0)};
        vecs[11] = '{in: 5'b00001, exp: mkexp(1, 0, 1, 2, 0, 0)};
        vecs[12] = '{in: 5'b00001, exp: mkexp(1, 0, 1, 3, 0, 0)};
        vecs[13] = '{in: 5'b00001, exp: mkexp(0, 0, 0, 0, 1, 0)};
        vecs[14] = '{in: 5'b00001, exp: mkexp(0, 0, 0, 0, 0, 0)};
        vecs[15] = '{in: 5'b10000, exp: mkexp(1, 0, 0, 0, 0, 0)};
        vecs[16] = '{in: 5'b01000, exp: mkexp(0, 0, 0, 0, 0, 0)};

        tick(2);
        check("reset_a", 32'(out_a), 32'd0);
        check("reset_b", 32'(out_b), 32'd0);
        rst_n = 1'b1;
        tick(1);

        for (int i = 0; i < 17; i++) begin
            {start, abort, lookup, intr, row_ack} = vecs[i].in;
            tick(1);
            check($sformatf("vec%0d", i), 32'(out_b), 32'(vecs[i].exp));
        end
        {start, abort, lookup, intr, row_ack} = 5'b0;

        // Timeout on B: WAIT_LOOKUP entered 4 edges after START, ERR 16 edges later.
        start = 1'b1; tick(1); start = 1'b0;
        tick(19);
        check("tmo_pre", 32'({if_b.busy, if_b.err}), 32'b10);
        tick(1);
        check("tmo_hit", 32'({if_b.busy, if_b.err}), 32'b01);
        tick(1);
        check("tmo_sticky", 32'(if_b.err), 32'd1);
        start = 1'b1; tick(1); start = 1'b0;
        check("err_clear", 32'({if_b.busy, if_b.err}), 32'b10);
        do_abort();

        // Slow ROW_ACK on B, three idle cycles per row.
        start = 1'b1; tick(1); start = 1'b0;
        tick(4);
        lookup = 1'b1; tick(1); lookup = 1'b0;
        intr = 1'b1; tick(1); intr = 1'b0;
        for (int r = 0; r < 4; r++) begin
            repeat (3) begin
                tick(1);
                check("ack_wait", 32'({if_b.row_req, if_b.row_idx}), 32'({1'b1, 6'(r)}));
            end
            row_ack = 1'b1; tick(1); row_ack = 1'b0;
            if (r < 3) check("ack_step", 32'({if_b.row_req, if_b.row_idx}), 32'({1'b1, 6'(r + 1)}));
            else check("ack_done", 32'({if_b.busy, if_b.row_req, if_b.done}), 32'b001);
        end
        tick(1);
        check("ack_done_low", 32'(if_b.done), 32'd0);
        do_abort();

        run_frame_a("nominal");
        do_abort();

        // ABORT while SCLK is high in the middle of a pulse.
        begin
            bit seen;
            seen = 1'b0;
            start = 1'b1; tick(1); start = 1'b0;
            for (int i = 0; i < 16 && !seen; i++) begin
                tick(1);
                seen = if_a.sclk;
            end
            check("sclk_rise_wait", 32'(seen), 32'd1);
            tick(1);
            abort = 1'b1; tick(1); abort = 1'b0;
            check("abort_trig", 32'({if_a.sclk, if_a.busy, if_a.done}), 32'd0);
            count_burst_a("after_abort");
        end

        // Asynchronous reset in READ at row 10.
        begin
            bit found;
            found = 1'b0;
            lookup = 1'b1; tick(1); lookup = 1'b0;
            intr = 1'b1; tick(1); intr = 1'b0;
            row_ack = 1'b1;
            for (int i = 0; i < 20 && !found; i++) begin
                if (if_a.row_idx == 6'd10 && if_a.row_req) found = 1'b1;
                else tick(1);
            end
            check("reach_row10", 32'(found), 32'd1);
            #2 rst_n = 1'b0;
            #1;
            check("rst_mid_a", 32'(out_a), 32'd0);
            check("rst_mid_b", 32'(out_b), 32'd0);
            row_ack = 1'b0;
            tick(2);
            rst_n = 1'b1;
            tick(1);
            run_frame_a("post_rst");
        end
        do_abort();

        for (int i = 0; i < 3000; i++) begin
            start   = ($urandom % 8) == 0;
            abort   = ($urandom % 64) == 0;
            lookup  = ($urandom % 4) == 0;
            intr    = ($urandom % 4) == 0;
            row_ack = ($urandom % 2) == 0;
            tick(1);
        end
        {start, abort, lookup, intr, row_ack} = 5'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
